// File: rtl/dbg_ahb_sram_slave.sv
// AHB-lite SRAM slave with programmable read wait states and a two-cycle ERROR response.
// Define DBG_SRAM_HWUSER_MASK_EN to take the write byte strobe from hwuser_i instead of hsize/haddr.
module dbg_ahb_sram_slave #(
    parameter int ADDR_W  = 10,
    parameter int RD_WAIT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hsel_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [31:0] haddr_i,
    input  logic [2:0]  hsize_i,
    input  logic [31:0] hwdata_i,
    input  logic [3:0]  hwuser_i,
    output logic        hready_o,
    output logic        hresp_o,
    output logic [31:0] hrdata_o
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_DATA = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_ERR1    = 3'd4;
    localparam logic [2:0] ST_ERR2    = 3'd5;

    localparam logic [2:0] WAIT_LOAD = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

    logic [2:0]        state_q, state_d;
    logic [2:0]        wait_q;
    logic [ADDR_W+1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [3:0]        user_q;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              req_err;
    logic              wr_en;
    logic [3:0]        strobe;
    logic [ADDR_W-1:0] wr_word, rd_word;
    logic [31:0]       rd_merged;
    logic              unused_cfg;
    logic              unused_trans;

    assign hready_o = (state_q != ST_RD_WAIT) && (state_q != ST_ERR1);
    assign hresp_o  = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign accept   = hsel_i && htrans_i[1] && hready_o;
    assign req_err  = (|haddr_i[31:ADDR_W+2]) || (hsize_i > 3'd2);
    assign unused_trans = htrans_i[0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RD_WAIT: if (wait_q == 3'd0) state_d = ST_RD_DATA;
            ST_ERR1:    state_d = ST_ERR2;
            // Every ready state may start the next transfer in the same cycle.
            default: begin
                if (!accept)             state_d = ST_IDLE;
                else if (req_err)        state_d = ST_ERR1;
                else if (hwrite_i)       state_d = ST_WR_DATA;
                else if (RD_WAIT > 0)    state_d = ST_RD_WAIT;
                else                     state_d = ST_RD_DATA;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            wait_q  <= 3'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            user_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= haddr_i[ADDR_W+1:0];
                write_q <= hwrite_i;
                size_q  <= hsize_i;
                user_q  <= hwuser_i;
                wait_q  <= WAIT_LOAD;
            end else if (state_q == ST_RD_WAIT && wait_q != 3'd0) begin
                wait_q <= wait_q - 3'd1;
            end
        end
    end

`ifdef DBG_SRAM_HWUSER_MASK_EN
    assign strobe     = user_q;
    assign unused_cfg = ^{size_q, addr_q[1:0]};
`else
    always_comb begin
        case (size_q)
            3'b000:  strobe = 4'b0001 << addr_q[1:0];
            3'b001:  strobe = addr_q[1] ? 4'b1100 : 4'b0011;
            default: strobe = 4'b1111;
        endcase
    end
    assign unused_cfg = ^user_q;
`endif

    assign wr_en   = (state_q == ST_WR_DATA) && write_q;
    assign wr_word = addr_q[ADDR_W+1:2];
    assign rd_word = (state_q == ST_RD_WAIT) ? addr_q[ADDR_W+1:2] : haddr_i[ADDR_W+1:2];

    // A zero-wait read accepted during a write data phase must see the bytes being written now.
    always_comb begin
        rd_merged = mem[rd_word];
        if (wr_en && (wr_word == rd_word)) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe[i]) rd_merged[8*i +: 8] = hwdata_i[8*i +: 8];
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive rst_i and only the control path restarts.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe[i]) mem[wr_word][8*i +: 8] <= hwdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hrdata_o <= '0;
        end else if (state_d == ST_RD_DATA) begin
            hrdata_o <= rd_merged;
        end
    end

endmodule

// File: tb/tb_dbg_ahb_sram_slave.sv
// Scoreboard bench for dbg_ahb_sram_slave: driver pushes expected responses, a negedge monitor pops and compares.
// A second instance with RD_WAIT=0 covers the zero-wait read path.
module tb_dbg_ahb_sram_slave;
    localparam int ADDR_W     = 10;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int TB_RD_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        hsel, hwrite, hready, hresp;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hsize;
    logic [3:0]  hwuser;

    logic        hsel_z, hwrite_z, hready_z, hresp_z;
    logic [1:0]  htrans_z;
    logic [31:0] haddr_z, hwdata_z, hrdata_z;
    logic [2:0]  hsize_z;
    logic [3:0]  hwuser_z;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          is_rd;
        bit          is_err;
        logic [31:0] data;
        int          stalls;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    bit          mon_active = 1'b0;
    int          mon_stalls = 0;
    logic [31:0] mem_m [DEPTH];

    always #5 clk = ~clk;

    dbg_ahb_sram_slave #(.ADDR_W(ADDR_W), .RD_WAIT(TB_RD_WAIT)) dut (
        .clk_i(clk), .rst_i(rst_i), .hsel_i(hsel), .htrans_i(htrans), .hwrite_i(hwrite),
        .haddr_i(haddr), .hsize_i(hsize), .hwdata_i(hwdata), .hwuser_i(hwuser),
        .hready_o(hready), .hresp_o(hresp), .hrdata_o(hrdata)
    );

    dbg_ahb_sram_slave #(.ADDR_W(ADDR_W), .RD_WAIT(0)) dut_z (
        .clk_i(clk), .rst_i(rst_i), .hsel_i(hsel_z), .htrans_i(htrans_z), .hwrite_i(hwrite_z),
        .haddr_i(haddr_z), .hsize_i(hsize_z), .hwdata_i(hwdata_z), .hwuser_i(hwuser_z),
        .hready_o(hready_z), .hresp_o(hresp_z), .hrdata_o(hrdata_z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte lanes touched by an access: the naturally aligned group of 2**size bytes holding addr.
    function automatic logic [3:0] lanes(input logic [31:0] addr, input logic [2:0] size);
        int nbytes = 1 << size;
        int base   = int'(addr[1:0]) & ~(nbytes - 1);
        logic [3:0] m = '0;
        for (int b = 0; b < 4; b++)
            if (b >= base && b < base + nbytes) m[b] = 1'b1;
        return m;
    endfunction

    task automatic idle(input int n);
        hsel   = 1'b0;
        htrans = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        exp_t       e;
        logic [3:0] m;
        bit         err;
        int         n;
        err    = (addr >= 32'(4 * DEPTH)) || (size > 3'd2);
        m      = err ? 4'b1111 : lanes(addr, size);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
        hwuser = m;
        n = 0;
        @(negedge clk);
        while (!hready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!hready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: hready stuck low at addr %h", addr);
        end
        @(posedge clk);
        #1;
        if (wr) hwdata = data;
        e.is_rd  = !wr;
        e.is_err = err;
        e.stalls = err ? 1 : (wr ? 0 : TB_RD_WAIT);
        e.data   = '0;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) mem_m[addr[ADDR_W+1:2]][8*b +: 8] = data[8*b +: 8];
            end else begin
                e.data = mem_m[addr[ADDR_W+1:2]];
            end
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            mon_active = 1'b0;
            mon_stalls = 0;
        end else begin
            if (mon_active) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard: data phase with no expected entry (t=%0t)", $time);
                    mon_active = 1'b0;
                end else begin
                    mon_e = exp_q[0];
                    check("hresp", {31'd0, hresp}, {31'd0, mon_e.is_err});
                    if (!hready) begin
                        mon_stalls++;
                    end else begin
                        void'(exp_q.pop_front());
                        check("stall_cycles", mon_stalls, mon_e.stalls);
                        if (mon_e.is_rd && !mon_e.is_err) check("hrdata", hrdata, mon_e.data);
                        mon_active = 1'b0;
                        mon_stalls = 0;
                    end
                end
            end
            if (hsel && htrans[1] && hready) mon_active = 1'b1;
        end
    end

    initial begin
        int n;
        int r;
        logic [31:0] a;
        hsel = 0; htrans = 0; hwrite = 0; haddr = 0; hsize = 0; hwdata = 0; hwuser = 0;
        hsel_z = 0; htrans_z = 0; hwrite_z = 0; haddr_z = 0; hsize_z = 0; hwdata_z = 0; hwuser_z = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hready", {31'd0, hready}, 32'd1);
        check("reset_hresp", {31'd0, hresp}, 32'd0);
        check("reset_hrdata", hrdata, 32'd0);
        check("reset_hrdata_z", hrdata_z, 32'd0);
        rst_i = 1'b1;
        idle(1);

        for (int w = 0; w < DEPTH; w++) issue(1'b1, 32'(w * 4), 3'd2, $urandom);
        idle(2);

        issue(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
        idle(1);
        issue(1'b0, 32'h10, 3'd2, 32'h0);
        idle(4);
        check("hold_after_word_read", hrdata, 32'hDEAD_BEEF);

        issue(1'b1, 32'h11, 3'd0, 32'h0000_5500);
        idle(1);
        issue(1'b0, 32'h10, 3'd2, 32'h0);
        idle(4);
        check("byte_merge", hrdata, 32'hDEAD_55EF);

        issue(1'b1, 32'h1000, 3'd2, 32'hCAFE_F00D);
        issue(1'b0, 32'h0, 3'd2, 32'h0);
        idle(4);

        issue(1'b1, 32'h0, 3'd2, 32'h1111_0000);
        issue(1'b1, 32'h4, 3'd2, 32'h2222_0004);
        issue(1'b1, 32'h8, 3'd2, 32'h3333_0008);
        issue(1'b0, 32'h0, 3'd2, 32'h0);
        issue(1'b0, 32'h4, 3'd2, 32'h0);
        issue(1'b0, 32'h8, 3'd2, 32'h0);
        issue(1'b1, 32'h20, 3'd2, 32'hA5A5_5A5A);
        issue(1'b0, 32'h20, 3'd2, 32'h0);
        idle(4);

        issue(1'b0, 32'h10, 3'd2, 32'h0);
        hsel   = 1'b0;
        htrans = 2'b00;
        #2;
        rst_i = 1'b0;
        #1;
        check("midreset_hready", {31'd0, hready}, 32'd1);
        check("midreset_hresp", {31'd0, hresp}, 32'd0);
        check("midreset_hrdata", hrdata, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        idle(1);
        issue(1'b0, 32'h10, 3'd2, 32'h0);
        idle(4);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
            if (r <= 3)      issue(1'b1, a, 3'($urandom_range(0, 2)), $urandom);
            else if (r <= 7) issue(1'b0, a, 3'($urandom_range(0, 2)), 32'h0);
            else if (r == 8) begin
                if ($urandom_range(0, 1) == 0)
                    issue(1'($urandom_range(0, 1)), a | (32'd1 << $urandom_range(ADDR_W + 2, 31)), 3'd2, $urandom);
                else
                    issue(1'($urandom_range(0, 1)), a, 3'($urandom_range(3, 7)), $urandom);
            end else idle($urandom_range(1, 2));
        end
        idle(1);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        hsel_z = 1'b1; htrans_z = 2'b10; hwrite_z = 1'b1; haddr_z = 32'h10; hsize_z = 3'd2; hwuser_z = 4'hF;
        @(posedge clk);
        #1;
        hwdata_z = 32'h1357_9BDF;
        hwrite_z = 1'b0;
        check("z_write_ready", {31'd0, hready_z}, 32'd1);
        @(posedge clk);
        #1;
        hsel_z = 1'b0; htrans_z = 2'b00;
        check("z_fwd_ready", {31'd0, hready_z}, 32'd1);
        check("z_fwd_resp", {31'd0, hresp_z}, 32'd0);
        check("z_fwd_data", hrdata_z, 32'h1357_9BDF);
        hsel_z = 1'b1; htrans_z = 2'b10; hwrite_z = 1'b1; haddr_z = 32'h20;
        @(posedge clk);
        #1;
        hwdata_z = 32'h2468_ACE0;
        hsel_z = 1'b0; htrans_z = 2'b00;
        @(posedge clk);
        #1;
        hsel_z = 1'b1; htrans_z = 2'b10; hwrite_z = 1'b0; haddr_z = 32'h20;
        @(posedge clk);
        #1;
        hsel_z = 1'b0; htrans_z = 2'b00;
        check("z_read_ready", {31'd0, hready_z}, 32'd1);
        check("z_read_data", hrdata_z, 32'h2468_ACE0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
